// File: rtl/vector_recorder_pkg.sv
// vector_recorder_pkg
// Types and helpers shared by the vector recorder files.
//   state_t     : FSM state type built on the shared encodings
//   depth_of()  : number of storage entries for a given address width
package vector_recorder_pkg;

`include "vector_recorder_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE    = `VR_STATE_IDLE,
    ST_ARMED   = `VR_STATE_ARMED,
    ST_CAPTURE = `VR_STATE_CAPTURE,
    ST_DRAIN   = `VR_STATE_DRAIN
  } state_t;

  function automatic int unsigned depth_of(input int unsigned log2_depth);
    return 32'd1 << log2_depth;
  endfunction

endpackage

// File: rtl/recorder_mem.sv
// recorder_mem
// DEPTH x WIDTH register array backing the vector recorder.
// Ports:
//   clock        : rising-edge clock for the write port
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : asynchronous (combinational) read port
// Contents are never reset; the recorder tracks validity with its count.
module recorder_mem
  import vector_recorder_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = depth_of(DEPTH_LOG2);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vector_recorder_defs.vh
// vector_recorder_defs.vh
// Shared state encodings for the vector recorder FSM. The numeric values
// are visible on the `state` port, so software and benches rely on them.
`ifndef VECTOR_RECORDER_DEFS_VH
`define VECTOR_RECORDER_DEFS_VH

`define VR_STATE_IDLE    2'd0
`define VR_STATE_ARMED   2'd1
`define VR_STATE_CAPTURE 2'd2
`define VR_STATE_DRAIN   2'd3

`endif

// File: rtl/vector_recorder.sv
// vector_recorder
// Capture buffer for test/debug: once armed and triggered it records
// qualified probe vectors, then drains them oldest-first over valid/ready.
// Ports:
//   clock, reset          : clock, synchronous active-low reset
//   arm, trigger, stop    : capture control (IDLE->ARMED->CAPTURE->DRAIN)
//   sample_valid/data     : probe vector stream to record
//   rd_valid/ready/data   : drain handshake, rd_last marks the final entry
//   count                 : entries currently held (0..DEPTH)
//   overflow              : sticky, an entry was overwritten (WRAP=1)
//   state                 : FSM state, IDLE=0 ARMED=1 CAPTURE=2 DRAIN=3
module vector_recorder
  import vector_recorder_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int WRAP       = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  stop,
  input  logic                  sample_valid,
  input  logic [WIDTH-1:0]      sample_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_last,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [1:0]            state
);

  localparam bit WRAP_EN = (WRAP != 0);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

  state_t                st;
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  ovf;

  logic                  full;
  logic                  cap_write;
  logic                  mem_we;
  logic                  grow;
  logic [DEPTH_LOG2:0]   cnt_after_write;
  logic                  rd_fire;

  // A sample is taken in CAPTURE and also in the trigger cycle itself.
  // When full without wrap nothing is written; in practice the FSM has
  // already left CAPTURE by then.
  always_comb begin
    full            = (cnt == DEPTH_CNT);
    cap_write       = sample_valid && ((st == ST_CAPTURE) || ((st == ST_ARMED) && trigger));
    mem_we          = cap_write && (WRAP_EN || !full);
    grow            = mem_we && !full;
    cnt_after_write = cnt + {{DEPTH_LOG2{1'b0}}, grow};
    rd_fire         = rd_valid && rd_ready;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      st   <= ST_IDLE;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          wptr <= '0;
          rptr <= '0;
          cnt  <= '0;
          ovf  <= 1'b0;
          if (arm) begin
            st <= ST_ARMED;
          end
        end

        // A stop arriving with the trigger is honoured: the trigger-cycle
        // sample (if any) is kept and the capture closes immediately.
        ST_ARMED: begin
          if (trigger) begin
            if (mem_we) begin
              wptr <= wptr + 1'b1;
              cnt  <= cnt_after_write;
            end
            if (stop) begin
              st <= (cnt_after_write == '0) ? ST_IDLE : ST_DRAIN;
            end else begin
              st <= ST_CAPTURE;
            end
          end
        end

        ST_CAPTURE: begin
          if (mem_we) begin
            wptr <= wptr + 1'b1;
            if (full) begin
              // Wrap overwrite: oldest entry is lost, window slides.
              rptr <= rptr + 1'b1;
              ovf  <= 1'b1;
            end else begin
              cnt <= cnt_after_write;
            end
          end
          if (!WRAP_EN && grow && (cnt_after_write == DEPTH_CNT)) begin
            st <= ST_DRAIN;
          end else if (stop) begin
            st <= (cnt_after_write == '0) ? ST_IDLE : ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (rd_fire) begin
            rptr <= rptr + 1'b1;
            cnt  <= cnt - 1'b1;
            if (rd_last) begin
              // Leave IDLE-ready: pointers and flags already cleared.
              st   <= ST_IDLE;
              wptr <= '0;
              rptr <= '0;
              ovf  <= 1'b0;
            end
          end
        end

        default: st <= ST_IDLE;
      endcase
    end
  end

  recorder_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (wptr),
    .wdata (sample_data),
    .raddr (rptr),
    .rdata (rd_data)
  );

  // Read side depends on registers only; rd_ready never feeds these.
  assign rd_valid = (st == ST_DRAIN) && (cnt != '0);
  assign rd_last  = rd_valid && (cnt == (DEPTH_LOG2+1)'(1));
  assign count    = cnt;
  assign overflow = ovf;
  assign state    = st;

endmodule

// File: tb/tb_vector_recorder.sv
// tb_vector_recorder
// Directed bench for vector_recorder: one instance with WRAP=0 and one
// with WRAP=1 share the stimulus; each scenario task checks its own
// expected values inline.
module tb_vector_recorder;

  localparam int W  = 32;
  localparam int DL = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0, trigger = 1'b0, stop = 1'b0;
  logic          sample_valid = 1'b0;
  logic [W-1:0]  sample_data = '0;
  logic          rd_ready = 1'b0;

  logic          rd_valid0, rd_last0, overflow0;
  logic [W-1:0]  rd_data0;
  logic [DL:0]   count0;
  logic [1:0]    state0;

  logic          rd_valid1, rd_last1, overflow1;
  logic [W-1:0]  rd_data1;
  logic [DL:0]   count1;
  logic [1:0]    state1;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] got_data[$];
  logic         got_last[$];

  always #5 clock = ~clock;

  vector_recorder #(.WIDTH(W), .DEPTH_LOG2(DL), .WRAP(0)) dut0 (
    .clock(clock), .reset(reset), .arm(arm), .trigger(trigger), .stop(stop),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_data(rd_data0),
    .rd_last(rd_last0), .count(count0), .overflow(overflow0), .state(state0)
  );

  vector_recorder #(.WIDTH(W), .DEPTH_LOG2(DL), .WRAP(1)) dut1 (
    .clock(clock), .reset(reset), .arm(arm), .trigger(trigger), .stop(stop),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .rd_valid(rd_valid1), .rd_ready(rd_ready), .rd_data(rd_data1),
    .rd_last(rd_last1), .count(count1), .overflow(overflow1), .state(state1)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 0; trigger = 0; stop = 0; sample_valid = 0; rd_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    step();
    reset = 1;
  endtask

  task automatic do_arm();
    arm = 1;
    step();
    arm = 0;
  endtask

  // Collects accepted entries with rd_ready always high, bounded by budget.
  task automatic drain(input bit which, input int budget);
    got_data.delete();
    got_last.delete();
    for (int c = 0; c < budget; c++) begin
      rd_ready = 1;
      if (which == 0 && rd_valid0) begin
        got_data.push_back(rd_data0); got_last.push_back(rd_last0);
      end
      if (which == 1 && rd_valid1) begin
        got_data.push_back(rd_data1); got_last.push_back(rd_last1);
      end
      step();
      if ((which == 0 && state0 == 2'd0) || (which == 1 && state1 == 2'd0)) break;
    end
    rd_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (state0 !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state0); end
    vectors++; if (count0 !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count0); end
    vectors++; if (overflow0 !== 1'b0 || overflow1 !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b/%b exp 0", overflow0, overflow1); end
    vectors++; if (rd_valid0 !== 1'b0 || rd_last0 !== 1'b0) begin miscompares++; $display("FAIL reset_rd got valid %b last %b exp 0", rd_valid0, rd_last0); end
  endtask

  task automatic test_basic();
    do_reset();
    do_arm();
    vectors++; if (state0 !== 2'd1) begin miscompares++; $display("FAIL basic_armed got %0d exp 1", state0); end
    trigger = 1; step(); trigger = 0;
    vectors++; if (state0 !== 2'd2) begin miscompares++; $display("FAIL basic_capture got %0d exp 2", state0); end
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1; sample_data = 32'h11 + i; step();
    end
    sample_valid = 0;
    vectors++; if (count0 !== 5'd5) begin miscompares++; $display("FAIL basic_count got %0d exp 5", count0); end
    stop = 1; step(); stop = 0;
    vectors++; if (state0 !== 2'd3 || rd_valid0 !== 1'b1) begin miscompares++; $display("FAIL basic_drain_entry got state %0d valid %b exp 3/1", state0, rd_valid0); end
    drain(0, 50);
    vectors++; if (got_data.size() != 5) begin miscompares++; $display("FAIL basic_drain_len got %0d exp 5", got_data.size()); end
    for (int i = 0; i < 5 && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== 32'h11 + i || got_last[i] !== (i == 4)) begin
        miscompares++;
        $display("FAIL basic_entry%0d got %h last %b exp %h last %b", i, got_data[i], got_last[i], 32'h11 + i, (i == 4));
      end
    end
    vectors++; if (state0 !== 2'd0 || count0 !== 5'd0) begin miscompares++; $display("FAIL basic_end got state %0d count %0d exp 0/0", state0, count0); end
  endtask

  task automatic test_autostop();
    do_reset();
    do_arm();
    for (int i = 0; i < 20; i++) begin
      trigger = (i == 0); sample_valid = 1; sample_data = i; step();
      if (i == 15) begin
        vectors++; if (state0 !== 2'd3 || count0 !== 5'd16) begin miscompares++; $display("FAIL autostop_full got state %0d count %0d exp 3/16", state0, count0); end
      end
    end
    trigger = 0; sample_valid = 0;
    vectors++; if (count0 !== 5'd16 || overflow0 !== 1'b0) begin miscompares++; $display("FAIL autostop_hold got count %0d ovf %b exp 16/0", count0, overflow0); end
    drain(0, 60);
    vectors++; if (got_data.size() != 16) begin miscompares++; $display("FAIL autostop_len got %0d exp 16", got_data.size()); end
    for (int i = 0; i < 16 && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== i || got_last[i] !== (i == 15)) begin
        miscompares++;
        $display("FAIL autostop_entry%0d got %h last %b exp %h", i, got_data[i], got_last[i], i);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    do_arm();
    for (int i = 0; i < 20; i++) begin
      trigger = (i == 0); sample_valid = 1; sample_data = i; step();
    end
    trigger = 0; sample_valid = 0;
    vectors++; if (state1 !== 2'd2 || count1 !== 5'd16 || overflow1 !== 1'b1) begin miscompares++; $display("FAIL wrap_full got state %0d count %0d ovf %b exp 2/16/1", state1, count1, overflow1); end
    stop = 1; step(); stop = 0;
    vectors++; if (state1 !== 2'd3 || overflow1 !== 1'b1) begin miscompares++; $display("FAIL wrap_drain_entry got state %0d ovf %b exp 3/1", state1, overflow1); end
    drain(1, 60);
    vectors++; if (got_data.size() != 16) begin miscompares++; $display("FAIL wrap_len got %0d exp 16", got_data.size()); end
    for (int i = 0; i < 16 && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== i + 4 || got_last[i] !== (i == 15)) begin
        miscompares++;
        $display("FAIL wrap_entry%0d got %h last %b exp %h", i, got_data[i], got_last[i], i + 4);
      end
    end
    vectors++; if (state1 !== 2'd0 || overflow1 !== 1'b0) begin miscompares++; $display("FAIL wrap_end got state %0d ovf %b exp 0/0", state1, overflow1); end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] held;
    logic         was_stalled;
    logic [W-1:0] acc[$];
    do_reset();
    do_arm();
    trigger = 1; step(); trigger = 0;
    for (int i = 0; i < 6; i++) begin
      sample_valid = 1; sample_data = 32'hA0 + i; step();
    end
    sample_valid = 0;
    stop = 1; step(); stop = 0;
    was_stalled = 0;
    held = '0;
    for (int c = 0; c < 60 && state0 == 2'd3; c++) begin
      rd_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (was_stalled) begin
        vectors++;
        if (rd_data0 !== held) begin miscompares++; $display("FAIL bp_hold cycle %0d got %h exp %h", c, rd_data0, held); end
      end
      if (rd_valid0 && rd_ready) acc.push_back(rd_data0);
      was_stalled = rd_valid0 && !rd_ready;
      held = rd_data0;
      step();
    end
    rd_ready = 0;
    vectors++; if (acc.size() != 6) begin miscompares++; $display("FAIL bp_len got %0d exp 6", acc.size()); end
    for (int i = 0; i < 6 && i < acc.size(); i++) begin
      vectors++;
      if (acc[i] !== 32'hA0 + i) begin miscompares++; $display("FAIL bp_entry%0d got %h exp %h", i, acc[i], 32'hA0 + i); end
    end
  endtask

  task automatic test_edge_cases();
    // stop together with the trigger sample
    do_reset();
    do_arm();
    trigger = 1; stop = 1; sample_valid = 1; sample_data = 32'h5A; step();
    trigger = 0; stop = 0; sample_valid = 0;
    vectors++; if (state0 !== 2'd3 || count0 !== 5'd1 || rd_last0 !== 1'b1 || rd_data0 !== 32'h5A) begin
      miscompares++; $display("FAIL edge_stop_trig got state %0d count %0d last %b data %h exp 3/1/1/5a", state0, count0, rd_last0, rd_data0);
    end
    drain(0, 10);
    vectors++; if (got_data.size() != 1 || state0 !== 2'd0) begin miscompares++; $display("FAIL edge_stop_trig_drain got len %0d state %0d exp 1/0", got_data.size(), state0); end
    // stop with nothing captured
    do_arm();
    trigger = 1; step(); trigger = 0;
    stop = 1; step(); stop = 0;
    vectors++; if (state0 !== 2'd0 || count0 !== 5'd0) begin miscompares++; $display("FAIL edge_empty_stop got state %0d count %0d exp 0/0", state0, count0); end
    // arm during capture
    do_arm();
    trigger = 1; step(); trigger = 0;
    sample_valid = 1; sample_data = 32'h77; step();
    arm = 1; sample_data = 32'h78; step();
    arm = 0; sample_valid = 0;
    vectors++; if (state0 !== 2'd2 || count0 !== 5'd2) begin miscompares++; $display("FAIL edge_arm_capture got state %0d count %0d exp 2/2", state0, count0); end
    stop = 1; step(); stop = 0;
    drain(0, 10);
    vectors++; if (got_data.size() != 2 || got_data[0] !== 32'h77 || got_data[1] !== 32'h78) begin
      miscompares++; $display("FAIL edge_arm_drain got len %0d exp 2 entries 77,78", got_data.size());
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    do_arm();
    trigger = 1; step(); trigger = 0;
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1; sample_data = 32'h31 + i; step();
    end
    sample_valid = 0;
    stop = 1; step(); stop = 0;
    rd_ready = 1; step(); step(); rd_ready = 0;
    vectors++; if (count0 !== 5'd3 || rd_data0 !== 32'h33) begin miscompares++; $display("FAIL rmd_partial got count %0d data %h exp 3/33", count0, rd_data0); end
    reset = 0; step(); reset = 1;
    vectors++; if (state0 !== 2'd0 || count0 !== 5'd0 || rd_valid0 !== 1'b0) begin
      miscompares++; $display("FAIL rmd_reset got state %0d count %0d valid %b exp 0/0/0", state0, count0, rd_valid0);
    end
    do_arm();
    trigger = 1; step(); trigger = 0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1; sample_data = 32'h41 + i; step();
    end
    sample_valid = 0;
    stop = 1; step(); stop = 0;
    drain(0, 20);
    vectors++; if (got_data.size() != 3) begin miscompares++; $display("FAIL rmd_len got %0d exp 3", got_data.size()); end
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== 32'h41 + i) begin miscompares++; $display("FAIL rmd_entry%0d got %h exp %h", i, got_data[i], 32'h41 + i); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_autostop();
    test_wrap();
    test_back_pressure();
    test_edge_cases();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
